// File: rtl/pixel_output_pkg.sv
// Shared mode encodings, colour-bar table and default widths for the pixel output path.
package pixel_output_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned PIX_W_DEF  = 8;

    typedef enum logic [2:0] {
        ModeBlack = 3'd0,
        ModeLp    = 3'd1,
        ModeHp    = 3'd2,
        ModeSplit = 3'd3,
        ModeBars  = 3'd4
    } mode_e;

    // Bar colours left to right as {r, g, b} on/off bits.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        rgb = 3'b000;
        case (idx)
            3'd0: rgb = 3'b111;
            3'd1: rgb = 3'b110;
            3'd2: rgb = 3'b011;
            3'd3: rgb = 3'b010;
            3'd4: rgb = 3'b101;
            3'd5: rgb = 3'b100;
            3'd6: rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/pixel_output_mux_scale.sv
// Combinational conversion of filter samples to display intensity, with high-pass clamp flag.
module pixel_scale
    import pixel_output_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned HP_SHIFT = 3
) (
    input  logic [DATA_W-1:0] lp_i,
    input  logic [DATA_W-1:0] hp_i,
    output logic [PIX_W-1:0]  lp8_o,
    output logic [PIX_W-1:0]  hp8_o,
    output logic              hp_sat_o
);

    logic [DATA_W:0] hp_ext;
    logic [DATA_W:0] hp_mag;
    logic [DATA_W:0] hp_shr;

    always_comb begin
        lp8_o  = lp_i[DATA_W-1 -: PIX_W];
        // One extra bit so the most negative sample has an exact magnitude.
        hp_ext = {hp_i[DATA_W-1], hp_i};
        hp_mag = hp_ext[DATA_W] ? (~hp_ext + {{DATA_W{1'b0}}, 1'b1}) : hp_ext;
        hp_shr = hp_mag >> HP_SHIFT;
        hp_sat_o = |hp_shr[DATA_W:PIX_W];
        hp8_o    = hp_sat_o ? {PIX_W{1'b1}} : hp_shr[PIX_W-1:0];
    end

endmodule

// File: rtl/pixel_output_mux.sv
// Two-stage pixel output mux: window/mode/scale capture in S1, colour selection in S2.
module pixel_output_mux
    import pixel_output_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned H_START  = 43,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_START  = 12,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned HP_SHIFT = 3
) (
    input  logic              clk9MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [9:0]        vgaCount,
    input  logic [8:0]        lineCount,
    input  logic [DATA_W-1:0] lowPassOutput,
    input  logic [DATA_W-1:0] highPassOutput,
    output logic [PIX_W-1:0]  redPixels,
    output logic [PIX_W-1:0]  greenPixels,
    output logic [PIX_W-1:0]  bluePixels,
    output logic              pixelValid,
    output logic              modeAck,
    output logic              hpSat
);

    localparam logic [9:0]  HLo   = 10'(H_START);
    localparam logic [9:0]  HHi   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]  HalfW = 10'(H_ACTIVE / 2);
    localparam int unsigned BarW  = H_ACTIVE / 8;
    localparam logic [8:0]  VLo   = 9'(V_START);
    localparam logic [8:0]  VHi   = 9'(V_START + V_ACTIVE);

    logic [PIX_W-1:0] lp8, hp8;
    logic             hp_sat;
    logic             in_active, frame_start;
    logic [9:0]       column;
    logic [2:0]       bar;

    logic             active_q, start_q, mode_chg_q, sat_acc_q, hp_sat_q;
    logic [PIX_W-1:0] lp8_q, hp8_q;
    logic [9:0]       column_q;
    logic [2:0]       bar_q;
    logic [2:0]       mode_q;

    logic [PIX_W-1:0] red_d, green_d, blue_d;
    logic [PIX_W-1:0] red_q, green_q, blue_q;
    logic             valid_q, ack_q;
    logic [2:0]       rgb;

    pixel_scale #(
        .DATA_W   (DATA_W),
        .PIX_W    (PIX_W),
        .HP_SHIFT (HP_SHIFT)
    ) u_scale (
        .lp_i     (lowPassOutput),
        .hp_i     (highPassOutput),
        .lp8_o    (lp8),
        .hp8_o    (hp8),
        .hp_sat_o (hp_sat)
    );

    always_comb begin
        in_active   = (vgaCount >= HLo) && (vgaCount < HHi) &&
                      (lineCount >= VLo) && (lineCount < VHi);
        frame_start = (vgaCount == 10'd0) && (lineCount == 9'd0);
        column      = vgaCount - HLo;
        bar         = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (column >= 10'(i * BarW)) bar = 3'(i);
        end
    end

    // S1: capture window, scaled samples and the frame-synchronous mode/saturation state.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            active_q   <= 1'b0;
            start_q    <= 1'b0;
            lp8_q      <= '0;
            hp8_q      <= '0;
            column_q   <= '0;
            bar_q      <= '0;
            mode_q     <= ModeBlack;
            mode_chg_q <= 1'b0;
            sat_acc_q  <= 1'b0;
            hp_sat_q   <= 1'b0;
        end else begin
            active_q   <= in_active;
            start_q    <= start;
            lp8_q      <= lp8;
            hp8_q      <= hp8;
            column_q   <= column;
            bar_q      <= bar;
            mode_chg_q <= 1'b0;
            if (frame_start) begin
                mode_q     <= mode;
                mode_chg_q <= (mode != mode_q);
                hp_sat_q   <= sat_acc_q;
                // A clamp on the frame-start sample belongs to the frame now beginning.
                sat_acc_q  <= hp_sat;
            end else begin
                sat_acc_q  <= sat_acc_q | hp_sat;
            end
        end
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        rgb     = bar_rgb(bar_q);
        if (active_q && start_q) begin
            case (mode_q)
                ModeLp: begin
                    red_d   = lp8_q;
                    green_d = lp8_q;
                    blue_d  = lp8_q;
                end
                ModeHp: begin
                    red_d   = hp8_q;
                    green_d = hp8_q;
                    blue_d  = hp8_q;
                end
                ModeSplit: begin
                    if (column_q >= HalfW) begin
                        green_d = hp8_q;
                    end else begin
                        red_d   = lp8_q;
                        green_d = lp8_q;
                        blue_d  = lp8_q;
                    end
                end
                ModeBars: begin
                    red_d   = {PIX_W{rgb[2]}};
                    green_d = {PIX_W{rgb[1]}};
                    blue_d  = {PIX_W{rgb[0]}};
                end
                default: ;
            endcase
        end
    end

    // S2: registered colour outputs.
    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            valid_q <= active_q;
            ack_q   <= mode_chg_q;
        end
    end

    assign redPixels   = red_q;
    assign greenPixels = green_q;
    assign bluePixels  = blue_q;
    assign pixelValid  = valid_q;
    assign modeAck     = ack_q;
    assign hpSat       = hp_sat_q;

endmodule

// File: tb/tb_pixel_output_mux.sv
// Table-driven scoreboard bench for pixel_output_mux plus hand sequences for saturation and reset.
module tb_pixel_output_mux;

    typedef struct {
        int          id;
        logic        st;
        logic [2:0]  md;
        logic [9:0]  h;
        logic [8:0]  v;
        logic [11:0] lp;
        logic [11:0] hp;
        logic [23:0] rgb;
        logic        vld;
        logic        ack;
        logic        chk;
    } vec_t;

    logic        clk9MHz = 1'b0;
    logic        reset, start;
    logic [2:0]  mode;
    logic [9:0]  vgaCount;
    logic [8:0]  lineCount;
    logic [11:0] lowPassOutput, highPassOutput;
    logic [7:0]  redPixels, greenPixels, bluePixels;
    logic        pixelValid, modeAck, hpSat;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb_q[$];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk9MHz = ~clk9MHz;

    pixel_output_mux dut (
        .clk9MHz        (clk9MHz),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .vgaCount       (vgaCount),
        .lineCount      (lineCount),
        .lowPassOutput  (lowPassOutput),
        .highPassOutput (highPassOutput),
        .redPixels      (redPixels),
        .greenPixels    (greenPixels),
        .bluePixels     (bluePixels),
        .pixelValid     (pixelValid),
        .modeAck        (modeAck),
        .hpSat          (hpSat)
    );

    task automatic chk24(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic [2:0] md,
                         input logic [9:0] h, input logic [8:0] v,
                         input logic [11:0] lp, input logic [11:0] hp);
        reset          = rst;
        start          = st;
        mode           = md;
        vgaCount       = h;
        lineCount      = v;
        lowPassOutput  = lp;
        highPassOutput = hp;
    endtask

    task automatic tick();
        @(posedge clk9MHz);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] md, input logic [9:0] h,
                                input logic [8:0] v, input logic [11:0] lp,
                                input logic [11:0] hp, input logic [23:0] rgb,
                                input logic vld, input logic ack);
        vec_t t;
        t.id = 0; t.st = st; t.md = md; t.h = h; t.v = v; t.lp = lp; t.hp = hp;
        t.rgb = rgb; t.vld = vld; t.ack = ack; t.chk = 1'b1;
        return t;
    endfunction

    task automatic add(input vec_t t);
        vec_t u;
        u = t;
        u.id = tbl.size();
        tbl.push_back(u);
    endtask

    // Outputs after each edge belong to the vector driven two edges earlier.
    task automatic sb_step(input vec_t t);
        vec_t e;
        drive(1'b0, t.st, t.md, t.h, t.v, t.lp, t.hp);
        sb_q.push_back(t);
        tick();
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            if (e.chk) begin
                chk24($sformatf("vec%0d rgb", e.id), {redPixels, greenPixels, bluePixels}, e.rgb);
                chk1($sformatf("vec%0d pixelValid", e.id), pixelValid, e.vld);
                chk1($sformatf("vec%0d modeAck", e.id), modeAck, e.ack);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t dummy;
        // Vectors: start, mode, h, v, lp, hp -> rgb, pixelValid, modeAck.
        add(mk(1, 3'd1, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd1, 10'd100, 9'd50,  12'hABC, 12'h000, 24'hABABAB, 1, 0));
        add(mk(1, 3'd1, 10'd42,  9'd50,  12'hABC, 12'h000, 24'h000000, 0, 0));
        add(mk(1, 3'd1, 10'd43,  9'd12,  12'h123, 12'h000, 24'h121212, 1, 0));
        add(mk(1, 3'd1, 10'd522, 9'd283, 12'hFFF, 12'h000, 24'hFFFFFF, 1, 0));
        add(mk(1, 3'd1, 10'd523, 9'd50,  12'hFFF, 12'h000, 24'h000000, 0, 0));
        add(mk(1, 3'd1, 10'd100, 9'd284, 12'hFFF, 12'h000, 24'h000000, 0, 0));
        add(mk(1, 3'd1, 10'd100, 9'd11,  12'hFFF, 12'h000, 24'h000000, 0, 0));
        add(mk(0, 3'd1, 10'd100, 9'd50,  12'hABC, 12'h000, 24'h000000, 1, 0));
        add(mk(1, 3'd1, 10'd101, 9'd50,  12'hABC, 12'h000, 24'hABABAB, 1, 0));
        add(mk(1, 3'd2, 10'd100, 9'd100, 12'h456, 12'h800, 24'h454545, 1, 0));
        add(mk(1, 3'd2, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd2, 10'd100, 9'd50,  12'h000, 12'h800, 24'hFFFFFF, 1, 0));
        add(mk(1, 3'd2, 10'd101, 9'd50,  12'h000, 12'hFB0, 24'h0A0A0A, 1, 0));
        add(mk(1, 3'd2, 10'd102, 9'd50,  12'h000, 12'h010, 24'h020202, 1, 0));
        add(mk(1, 3'd2, 10'd103, 9'd50,  12'h000, 12'h7F8, 24'hFFFFFF, 1, 0));
        add(mk(1, 3'd4, 10'd104, 9'd50,  12'hFFF, 12'h010, 24'h020202, 1, 0));
        add(mk(1, 3'd3, 10'd105, 9'd50,  12'hFFF, 12'h010, 24'h020202, 1, 0));
        add(mk(1, 3'd3, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd3, 10'd282, 9'd50,  12'hFFF, 12'h010, 24'hFFFFFF, 1, 0));
        add(mk(1, 3'd3, 10'd283, 9'd50,  12'hFFF, 12'h010, 24'h000200, 1, 0));
        add(mk(1, 3'd3, 10'd43,  9'd50,  12'h800, 12'hFB0, 24'h808080, 1, 0));
        add(mk(1, 3'd3, 10'd522, 9'd50,  12'h800, 12'hFB0, 24'h000A00, 1, 0));
        add(mk(1, 3'd3, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 0));
        add(mk(1, 3'd4, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        for (int i = 0; i < 8; i++) begin
            add(mk(1, 3'd4, 10'(43 + 60 * i), 9'd50, 12'h000, 12'h000, bars[i], 1, 0));
            add(mk(1, 3'd4, 10'(43 + 60 * i + 59), 9'd50, 12'h000, 12'h000, bars[i], 1, 0));
        end
        add(mk(0, 3'd4, 10'd103, 9'd50,  12'h000, 12'h000, 24'h000000, 1, 0));
        add(mk(1, 3'd5, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd5, 10'd100, 9'd50,  12'hFFF, 12'h800, 24'h000000, 1, 0));
        add(mk(1, 3'd0, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd0, 10'd100, 9'd50,  12'hFFF, 12'h000, 24'h000000, 1, 0));
        add(mk(1, 3'd7, 10'd0,   9'd0,   12'h000, 12'h000, 24'h000000, 0, 1));
        add(mk(1, 3'd7, 10'd100, 9'd50,  12'hFFF, 12'h000, 24'h000000, 1, 0));

        // Reset state.
        drive(1'b1, 1'b1, 3'd1, 10'd100, 9'd50, 12'hABC, 12'h800);
        tick();
        tick();
        chk24("reset rgb", {redPixels, greenPixels, bluePixels}, 24'h000000);
        chk1("reset pixelValid", pixelValid, 1'b0);
        chk1("reset modeAck", modeAck, 1'b0);
        chk1("reset hpSat", hpSat, 1'b0);

        foreach (tbl[i]) sb_step(tbl[i]);
        dummy = mk(0, 3'd0, 10'd0, 9'd1, 12'h000, 12'h000, 24'h000000, 0, 0);
        dummy.chk = 1'b0;
        sb_step(dummy);
        sb_q.delete();

        // Saturation flag: sticky per frame, coincident event goes to the new frame.
        drive(1'b1, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        chk1("sat clean", hpSat, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 10'd100, 9'd50, 12'h000, 12'h800);
        tick();
        chk1("sat sticky until frame", hpSat, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 10'd101, 9'd50, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        chk1("sat transfer", hpSat, 1'b1);
        drive(1'b0, 1'b1, 3'd2, 10'd100, 9'd50, 12'h000, 12'h000);
        tick();
        chk1("sat held", hpSat, 1'b1);
        drive(1'b0, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        chk1("sat clear", hpSat, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h800);
        tick();
        chk1("sat coincident old frame", hpSat, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 10'd100, 9'd50, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd2, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        chk1("sat coincident new frame", hpSat, 1'b1);

        // Reset mid-frame with colour bars showing.
        drive(1'b1, 1'b1, 3'd4, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd4, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd4, 10'd43, 9'd50, 12'h000, 12'h000);
        tick();
        tick();
        tick();
        chk24("bars before reset", {redPixels, greenPixels, bluePixels}, 24'hFFFFFF);
        drive(1'b1, 1'b1, 3'd4, 10'd43, 9'd50, 12'h000, 12'h000);
        tick();
        chk24("reset mid rgb", {redPixels, greenPixels, bluePixels}, 24'h000000);
        chk1("reset mid pixelValid", pixelValid, 1'b0);
        drive(1'b0, 1'b1, 3'd4, 10'd43, 9'd50, 12'h000, 12'h000);
        tick();
        tick();
        tick();
        chk24("black after reset", {redPixels, greenPixels, bluePixels}, 24'h000000);
        chk1("valid after reset", pixelValid, 1'b1);
        drive(1'b0, 1'b1, 3'd4, 10'd0, 9'd0, 12'h000, 12'h000);
        tick();
        drive(1'b0, 1'b1, 3'd4, 10'd43, 9'd50, 12'h000, 12'h000);
        tick();
        chk1("ack after reset frame", modeAck, 1'b1);
        tick();
        chk24("bars after frame start", {redPixels, greenPixels, bluePixels}, 24'hFFFFFF);
        chk1("ack single pulse", modeAck, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_output_mux.md
PIXEL_OUTPUT_MUX -- requirements
Module: pixel_output_mux

Interface
REQ-001 Parameter DATA_W, 12, filter sample width.
REQ-002 Parameter PIX_W, 8, colour channel width.
REQ-003 Parameter H_START, 43, first active vgaCount value.
REQ-004 Parameter H_ACTIVE, 480, active pixels per line.
REQ-005 Parameter V_START, 12, first active lineCount value.
REQ-006 Parameter V_ACTIVE, 272, active lines per frame.
REQ-007 Parameter HP_SHIFT, 3, right shift applied to high-pass magnitude.
REQ-008 clk9MHz  input  1  pixel clock; the block SHALL have exactly one clock, and every register SHALL be clocked on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 start  input  1  display enable; low forces black.
REQ-011 mode  input  3  display mode request.
REQ-012 vgaCount  input  10  horizontal position.
REQ-013 lineCount  input  9  vertical position.
REQ-014 lowPassOutput  input  DATA_W  unsigned low-pass sample.
REQ-015 highPassOutput  input  DATA_W  two's-complement high-pass sample.
REQ-016 redPixels, greenPixels, bluePixels  output  PIX_W each  registered colour outputs.
REQ-017 pixelValid  output  1  high when the current outputs belong to the active window.
REQ-018 modeAck  output  1  one-cycle pulse when a new mode is adopted.
REQ-019 hpSat  output  1  sticky flag; high-pass saturation occurred in the previous frame.

Function
REQ-020 Pipeline: inputs sampled in S1, colour outputs in S2; latency 2 cycles for data, counts, start and the active flag.
REQ-021 Active window: H_START <= vgaCount < H_START+H_ACTIVE and V_START <= lineCount < V_START+V_ACTIVE; outside it, all colours SHALL be 0 and pixelValid SHALL be 0.
REQ-022 The registered mode SHALL update only at frame start (vgaCount==0 and lineCount==0); modeAck SHALL pulse 2 cycles later only if the value changed.
REQ-023 Mode changes mid-frame SHALL be ignored until the next frame start; the last request before frame start wins.
REQ-024 Low-pass scale: LP8 = lowPassOutput[DATA_W-1 -: PIX_W], truncation only.
REQ-025 High-pass scale: HP8 = min(|highPassOutput| >> HP_SHIFT, 2^PIX_W-1), computed at DATA_W+1 bits so |-2048| = 2048 is exact; clamping SHALL set the saturation event.
REQ-026 Mode 0: black.
REQ-027 Mode 1: grey LP8 on R, G and B.
REQ-028 Mode 2: grey HP8 on R, G and B.
REQ-029 Mode 3: split screen; left half of the active window shows LP8 grey, right half (column >= H_ACTIVE/2) shows HP8 in green only.
REQ-030 Mode 4: eight vertical colour bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black, at full scale.
REQ-031 Modes 5-7 SHALL behave as mode 0.
REQ-032 When start is low, all colours SHALL be 0 within 2 cycles, while pixelValid keeps tracking the window; start returning high SHALL resume output on the next cycle's data with no frame resync.
REQ-033 hpSat: saturation events accumulate during a frame; at frame start the accumulated value transfers to hpSat and the accumulator clears.
REQ-034 Events and the frame-start transfer coincident in one cycle: the event SHALL count toward the new frame.

Reset
REQ-035 On reset: colours 0, pixelValid 0, modeAck 0, hpSat 0, accumulator 0, registered mode 0, all pipeline valid and start stages 0.
REQ-036 Reset asserted mid-frame SHALL take effect on the next edge; after release, the registered mode SHALL stay 0 until the next frame start.

Structure
REQ-037 Package pixel_output_pkg SHALL hold the mode encodings, the colour-bar table, and the default DATA_W/PIX_W constants.
REQ-038 Sub-module pixel_scale SHALL hold the LP/HP conversion and the saturation flag; it SHALL be combinational and instantiated twice only if needed for split mode.

Verification
REQ-039 Reset, start=1, mode=1, lowPassOutput=12'hABC at vgaCount=100, lineCount=50 -> 2 cycles later R=G=B=8'hAB, pixelValid=1.
REQ-040 mode=2, highPassOutput=12'h800 (-2048) -> HP8=8'hFF, hpSat=1 after the next frame start; highPassOutput=-80 -> HP8=10.
REQ-041 mode changes 1->4 at lineCount=100 -> output stays mode 1 until frame start, modeAck pulses once, first active pixel is white and column 60 is yellow.
REQ-042 mode=3, LP=12'hFFF, HP=12'h010 -> column 239 is R=G=B=FF; column 240 is R=0, G=2, B=0.
REQ-043 start dropped at an active pixel -> colours 0 two cycles later, pixelValid unchanged; vgaCount=H_START-1 or lineCount=V_START+V_ACTIVE -> all 0.
REQ-044 reset pulsed mid-frame with mode=4 -> outputs 0 next edge, black until the following frame start.
